// File: rtl/hazard_tag_pipe_pkg.sv
// Shared definitions for the hazard tag pipeline: field widths, the
// "ignore"/"no use" timing codes, the tag record, the BUBBLE tag and age().
package hazard_tag_pipe_pkg;

    localparam int REG_W = 5;
    localparam int T_W   = 2;

    localparam logic [T_W-1:0] T_NEW_IGNORE = 2'd3;
    localparam logic [T_W-1:0] T_USE_NONE   = 2'd3;

    typedef struct packed {
        logic [REG_W-1:0] rs_base;
        logic [REG_W-1:0] rt;
        logic [T_W-1:0]   t_use_rs_base;
        logic [T_W-1:0]   t_use_rt;
        logic [T_W-1:0]   t_new;
        logic [REG_W-1:0] write_number;
        logic             write_enable;
    } tag_t;

    localparam tag_t BUBBLE_TAG = '{
        rs_base:       5'd0,
        rt:            5'd0,
        t_use_rs_base: T_USE_NONE,
        t_use_rt:      T_USE_NONE,
        t_new:         T_NEW_IGNORE,
        write_number:  5'd0,
        write_enable:  1'b0
    };

    // 3 means "not applicable" and 0 means "already due"; both are fixed points.
    function automatic logic [T_W-1:0] age_field(input logic [T_W-1:0] t);
        if (t == 2'd3 || t == 2'd0) begin
            return t;
        end
        return t - 2'd1;
    endfunction

    function automatic tag_t age_tag(input tag_t t);
        tag_t r;
        r               = t;
        r.t_new         = age_field(t.t_new);
        r.t_use_rs_base = age_field(t.t_use_rs_base);
        r.t_use_rt      = age_field(t.t_use_rt);
        return r;
    endfunction

endpackage

// File: rtl/hazard_tag_pipe_if.sv
// Bus between the hazard controller and the tag pipeline: stall request and
// D-stage tag in, E/M/W stage tags, fetch enables and stall statistics out.
interface hazard_tag_pipe_if #(parameter int CNT_W = 32);
    import hazard_tag_pipe_pkg::*;

    logic             stall;
    logic [REG_W-1:0] D_rs_base;
    logic [REG_W-1:0] D_rt;
    logic [T_W-1:0]   D_T_use_rs_base;
    logic [T_W-1:0]   D_T_use_rt;
    logic [T_W-1:0]   D_T_new;
    logic [REG_W-1:0] D_REG_write_number;
    logic             D_REG_write_enable;

    logic [REG_W-1:0] E_rs_base, M_rs_base, W_rs_base;
    logic [REG_W-1:0] E_rt, M_rt, W_rt;
    logic [T_W-1:0]   E_T_use_rs_base, M_T_use_rs_base, W_T_use_rs_base;
    logic [T_W-1:0]   E_T_use_rt, M_T_use_rt, W_T_use_rt;
    logic [T_W-1:0]   E_T_new, M_T_new, W_T_new;
    logic [REG_W-1:0] E_REG_write_number, M_REG_write_number, W_REG_write_number;
    logic             E_REG_write_enable, M_REG_write_enable, W_REG_write_enable;

    logic             PC_enable;
    logic             FD_enable;
    logic [CNT_W-1:0] stall_cycles;
    logic             stall_timeout;

    modport master (
        output stall, D_rs_base, D_rt, D_T_use_rs_base, D_T_use_rt, D_T_new,
               D_REG_write_number, D_REG_write_enable,
        input  E_rs_base, M_rs_base, W_rs_base, E_rt, M_rt, W_rt,
               E_T_use_rs_base, M_T_use_rs_base, W_T_use_rs_base,
               E_T_use_rt, M_T_use_rt, W_T_use_rt,
               E_T_new, M_T_new, W_T_new,
               E_REG_write_number, M_REG_write_number, W_REG_write_number,
               E_REG_write_enable, M_REG_write_enable, W_REG_write_enable,
               PC_enable, FD_enable, stall_cycles, stall_timeout
    );

    modport slave (
        input  stall, D_rs_base, D_rt, D_T_use_rs_base, D_T_use_rt, D_T_new,
               D_REG_write_number, D_REG_write_enable,
        output E_rs_base, M_rs_base, W_rs_base, E_rt, M_rt, W_rt,
               E_T_use_rs_base, M_T_use_rs_base, W_T_use_rs_base,
               E_T_use_rt, M_T_use_rt, W_T_use_rt,
               E_T_new, M_T_new, W_T_new,
               E_REG_write_number, M_REG_write_number, W_REG_write_number,
               E_REG_write_enable, M_REG_write_enable, W_REG_write_enable,
               PC_enable, FD_enable, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/hazard_tag_pipe_stage.sv
// One pipeline stage tag register: loads either a BUBBLE or the incoming tag,
// optionally aged by one stage on the way in.
module hazard_tag_stage
    import hazard_tag_pipe_pkg::*;
#(
    parameter bit AGE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bubble,
    input  tag_t in_tag,
    output tag_t tag
);

    tag_t next_tag;

    // Select what the register captures at the next edge.
    always_comb begin
        next_tag = in_tag;
        if (bubble) begin
            next_tag = BUBBLE_TAG;
        end else if (AGE) begin
            next_tag = age_tag(in_tag);
        end
    end

    // Stage register; reset drops straight to BUBBLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag <= BUBBLE_TAG;
        end else begin
            tag <= next_tag;
        end
    end

endmodule

// File: rtl/hazard_tag_pipe.sv
// Write-side companion of the hazard controller: carries hazard tags through
// E/M/W, inserts bubbles on stall, and keeps stall statistics and a watchdog.
module hazard_tag_pipe
    import hazard_tag_pipe_pkg::*;
#(
    parameter int WDOG_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    hazard_tag_pipe_if.slave bus
);

    localparam int RUN_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(WDOG_LIMIT);

    tag_t             d_tag;
    tag_t             e_tag;
    tag_t             m_tag;
    tag_t             w_tag;
    logic [CNT_W-1:0] stall_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             timeout;

    // Build the E-entry tag; a non-writing or $0 destination never creates a hazard.
    always_comb begin
        d_tag = '{
            rs_base:       bus.D_rs_base,
            rt:            bus.D_rt,
            t_use_rs_base: bus.D_T_use_rs_base,
            t_use_rt:      bus.D_T_use_rt,
            t_new:         bus.D_T_new,
            write_number:  bus.D_REG_write_number,
            write_enable:  bus.D_REG_write_enable
        };
        if (!bus.D_REG_write_enable || bus.D_REG_write_number == '0) begin
            d_tag.write_enable = 1'b0;
            d_tag.write_number = '0;
            d_tag.t_new        = T_NEW_IGNORE;
        end
    end

    hazard_tag_stage #(.AGE(1'b0)) e_stage (
        .clk(clk), .reset_n(reset_n), .bubble(bus.stall), .in_tag(d_tag), .tag(e_tag)
    );
    hazard_tag_stage #(.AGE(1'b1)) m_stage (
        .clk(clk), .reset_n(reset_n), .bubble(1'b0), .in_tag(e_tag), .tag(m_tag)
    );
    hazard_tag_stage #(.AGE(1'b1)) w_stage (
        .clk(clk), .reset_n(reset_n), .bubble(1'b0), .in_tag(m_tag), .tag(w_tag)
    );

    // Length of the current stall run, held at the limit once reached.
    always_comb begin
        run_next = '0;
        if (bus.stall) begin
            run_next = (run_cnt == RUN_LIMIT) ? run_cnt : run_cnt + RUN_W'(1);
        end
    end

    // Saturating stall counter, run counter and sticky watchdog flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            run_cnt   <= '0;
            timeout   <= 1'b0;
        end else begin
            if (bus.stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            run_cnt <= run_next;
            if (run_next == RUN_LIMIT) begin
                timeout <= 1'b1;
            end
        end
    end

    assign bus.PC_enable     = !bus.stall;
    assign bus.FD_enable     = !bus.stall;
    assign bus.stall_cycles  = stall_cnt;
    assign bus.stall_timeout = timeout;

    assign bus.E_rs_base          = e_tag.rs_base;
    assign bus.E_rt               = e_tag.rt;
    assign bus.E_T_use_rs_base    = e_tag.t_use_rs_base;
    assign bus.E_T_use_rt         = e_tag.t_use_rt;
    assign bus.E_T_new            = e_tag.t_new;
    assign bus.E_REG_write_number = e_tag.write_number;
    assign bus.E_REG_write_enable = e_tag.write_enable;

    assign bus.M_rs_base          = m_tag.rs_base;
    assign bus.M_rt               = m_tag.rt;
    assign bus.M_T_use_rs_base    = m_tag.t_use_rs_base;
    assign bus.M_T_use_rt         = m_tag.t_use_rt;
    assign bus.M_T_new            = m_tag.t_new;
    assign bus.M_REG_write_number = m_tag.write_number;
    assign bus.M_REG_write_enable = m_tag.write_enable;

    assign bus.W_rs_base          = w_tag.rs_base;
    assign bus.W_rt               = w_tag.rt;
    assign bus.W_T_use_rs_base    = w_tag.t_use_rs_base;
    assign bus.W_T_use_rt         = w_tag.t_use_rt;
    assign bus.W_T_new            = w_tag.t_new;
    assign bus.W_REG_write_number = w_tag.write_number;
    assign bus.W_REG_write_enable = w_tag.write_enable;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Testbench for hazard_tag_pipe: table vectors, hand-written corner sequences
// and randomized traffic against a history-based reference model.
module tb_hazard_tag_pipe;

    typedef struct packed {
        logic [4:0] rs_base;
        logic [4:0] rt;
        logic [1:0] t_use_rs_base;
        logic [1:0] t_use_rt;
        logic [1:0] t_new;
        logic [4:0] write_number;
        logic       write_enable;
    } m_tag_t;

    localparam m_tag_t BUBBLE = '{5'd0, 5'd0, 2'd3, 2'd3, 2'd3, 5'd0, 1'b0};

    typedef struct {
        logic       stall;
        logic [4:0] wn;
        logic       we;
        logic [1:0] tnew;
        logic       exp_we;
        logic [4:0] exp_wn;
        logic [1:0] exp_tnew;
        logic       exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hazard_tag_pipe_if #(.CNT_W(32)) bus ();

    hazard_tag_pipe #(.WDOG_LIMIT(16), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the last three tags that entered E (index 2 newest),
    // total stalled edges, current stall run length and the sticky flag.
    m_tag_t      hist [3];
    logic [31:0] exp_cycles;
    int          exp_run;
    logic        exp_timeout;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] age_val(input logic [1:0] v, input int k);
        if (v == 2'd3) return v;
        if (int'(v) <= k) return 2'd0;
        return 2'(int'(v) - k);
    endfunction

    function automatic m_tag_t age_by(input m_tag_t t, input int k);
        m_tag_t r;
        r               = t;
        r.t_new         = age_val(t.t_new, k);
        r.t_use_rs_base = age_val(t.t_use_rs_base, k);
        r.t_use_rt      = age_val(t.t_use_rt, k);
        return r;
    endfunction

    function automatic m_tag_t d_entry();
        m_tag_t r;
        r = '{bus.D_rs_base, bus.D_rt, bus.D_T_use_rs_base, bus.D_T_use_rt,
              bus.D_T_new, bus.D_REG_write_number, bus.D_REG_write_enable};
        if (!bus.D_REG_write_enable || bus.D_REG_write_number == 5'd0) begin
            r.write_enable = 1'b0;
            r.write_number = 5'd0;
            r.t_new        = 2'd3;
        end
        return r;
    endfunction

    function automatic m_tag_t dut_tag(input int s);
        m_tag_t r;
        case (s)
            0: r = '{bus.E_rs_base, bus.E_rt, bus.E_T_use_rs_base, bus.E_T_use_rt,
                     bus.E_T_new, bus.E_REG_write_number, bus.E_REG_write_enable};
            1: r = '{bus.M_rs_base, bus.M_rt, bus.M_T_use_rs_base, bus.M_T_use_rt,
                     bus.M_T_new, bus.M_REG_write_number, bus.M_REG_write_enable};
            default: r = '{bus.W_rs_base, bus.W_rt, bus.W_T_use_rs_base, bus.W_T_use_rt,
                           bus.W_T_new, bus.W_REG_write_number, bus.W_REG_write_enable};
        endcase
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = BUBBLE;
        exp_cycles  = 32'd0;
        exp_run     = 0;
        exp_timeout = 1'b0;
    endtask

    task automatic apply_stimulus(input logic st, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [1:0] urs, input logic [1:0] urt,
                                  input logic [1:0] tn, input logic [4:0] wn, input logic we);
        bus.stall              = st;
        bus.D_rs_base          = rs;
        bus.D_rt               = rt;
        bus.D_T_use_rs_base    = urs;
        bus.D_T_use_rt         = urt;
        bus.D_T_new            = tn;
        bus.D_REG_write_number = wn;
        bus.D_REG_write_enable = we;
    endtask

    // Advance the model with the inputs present at the edge, then the clock.
    task automatic tick();
        m_tag_t entry;
        entry   = bus.stall ? BUBBLE : d_entry();
        hist[0] = hist[1];
        hist[1] = hist[2];
        hist[2] = entry;
        if (bus.stall) begin
            if (exp_cycles != 32'hFFFF_FFFF) exp_cycles++;
            exp_run++;
        end else begin
            exp_run = 0;
        end
        if (exp_run >= 16) exp_timeout = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string name);
        check_output({name, "_E"}, 32'(dut_tag(0)), 32'(hist[2]));
        check_output({name, "_M"}, 32'(dut_tag(1)), 32'(age_by(hist[1], 1)));
        check_output({name, "_W"}, 32'(dut_tag(2)), 32'(age_by(hist[0], 2)));
        check_output({name, "_cycles"}, bus.stall_cycles, exp_cycles);
        check_output({name, "_timeout"}, 32'(bus.stall_timeout), 32'(exp_timeout));
        check_output({name, "_pc_en"}, 32'(bus.PC_enable), 32'(!bus.stall));
        check_output({name, "_fd_en"}, 32'(bus.FD_enable), 32'(!bus.stall));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b0, 5'd8,  1'b1, 2'd2, 1'b1, 5'd8,  2'd2, 1'b1};
        vecs[1] = '{1'b0, 5'd0,  1'b1, 2'd1, 1'b0, 5'd0,  2'd3, 1'b1};
        vecs[2] = '{1'b0, 5'd5,  1'b0, 2'd1, 1'b0, 5'd0,  2'd3, 1'b1};
        vecs[3] = '{1'b1, 5'd9,  1'b1, 2'd2, 1'b0, 5'd0,  2'd3, 1'b0};
        vecs[4] = '{1'b0, 5'd31, 1'b1, 2'd0, 1'b1, 5'd31, 2'd0, 1'b1};
        vecs[5] = '{1'b0, 5'd1,  1'b1, 2'd3, 1'b1, 5'd1,  2'd3, 1'b1};

        apply_stimulus(1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0);
        do_reset();
        check_model("reset");

        // Table vectors: E-entry normalisation and bubble insertion.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].stall, 5'd3, 5'd4, 2'd1, 2'd2, vecs[i].tnew, vecs[i].wn, vecs[i].we);
            #1;
            check_output($sformatf("vec%0d_pc_en", i), 32'(bus.PC_enable), 32'(vecs[i].exp_pc));
            tick();
            check_output($sformatf("vec%0d_E_we", i), 32'(bus.E_REG_write_enable), 32'(vecs[i].exp_we));
            check_output($sformatf("vec%0d_E_wn", i), 32'(bus.E_REG_write_number), 32'(vecs[i].exp_wn));
            check_output($sformatf("vec%0d_E_tnew", i), 32'(bus.E_T_new), 32'(vecs[i].exp_tnew));
            check_model($sformatf("vec%0d", i));
        end

        // Flow: T_new 2 counts down through E, M, W.
        apply_stimulus(1'b0, 5'd2, 5'd7, 2'd3, 2'd3, 2'd2, 5'd8, 1'b1);
        tick();
        check_output("flow_E_tnew", 32'(bus.E_T_new), 32'd2);
        apply_stimulus(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b0);
        tick();
        check_output("flow_M_tnew", 32'(bus.M_T_new), 32'd1);
        tick();
        check_output("flow_W_tnew", 32'(bus.W_T_new), 32'd0);
        check_output("flow_W_wn", 32'(bus.W_REG_write_number), 32'd8);
        check_model("flow");

        // Load-use: one stall cycle inserts a bubble while E advances to M.
        apply_stimulus(1'b0, 5'd1, 5'd2, 2'd0, 2'd1, 2'd2, 5'd4, 1'b1);
        tick();
        apply_stimulus(1'b1, 5'd4, 5'd6, 2'd0, 2'd1, 2'd2, 5'd10, 1'b1);
        #1;
        check_output("lu_pc_en", 32'(bus.PC_enable), 32'd0);
        check_output("lu_fd_en", 32'(bus.FD_enable), 32'd0);
        tick();
        check_output("lu_E_we", 32'(bus.E_REG_write_enable), 32'd0);
        check_output("lu_E_tnew", 32'(bus.E_T_new), 32'd3);
        check_output("lu_M_tnew", 32'(bus.M_T_new), 32'd1);
        check_output("lu_M_wn", 32'(bus.M_REG_write_number), 32'd4);
        apply_stimulus(1'b0, 5'd4, 5'd6, 2'd0, 2'd1, 2'd2, 5'd10, 1'b1);
        tick();
        check_model("lu_replay");

        // Saturation: T_use 1 reaches 0 and stays; T_use 3 never moves.
        apply_stimulus(1'b0, 5'd5, 5'd6, 2'd3, 2'd1, 2'd3, 5'd0, 1'b0);
        tick();
        apply_stimulus(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd3, 5'd0, 1'b0);
        tick();
        check_output("sat_M_use_rt", 32'(bus.M_T_use_rt), 32'd0);
        check_output("sat_M_use_rs", 32'(bus.M_T_use_rs_base), 32'd3);
        tick();
        check_output("sat_W_use_rt", 32'(bus.W_T_use_rt), 32'd0);
        check_output("sat_W_use_rs", 32'(bus.W_T_use_rs_base), 32'd3);

        // Watchdog: 16 consecutive stalls set the sticky flag.
        do_reset();
        apply_stimulus(1'b1, 5'd1, 5'd1, 2'd1, 2'd1, 2'd1, 5'd3, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        check_output("wd_pre_timeout", 32'(bus.stall_timeout), 32'd0);
        tick();
        check_output("wd_timeout", 32'(bus.stall_timeout), 32'd1);
        check_output("wd_cycles", bus.stall_cycles, 32'd16);
        apply_stimulus(1'b0, 5'd1, 5'd1, 2'd1, 2'd1, 2'd1, 5'd3, 1'b1);
        tick();
        check_output("wd_sticky", 32'(bus.stall_timeout), 32'd1);
        check_model("wd");

        // Reset mid-stall clears everything without a clock edge.
        apply_stimulus(1'b1, 5'd2, 5'd3, 2'd1, 2'd1, 2'd2, 5'd7, 1'b1);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check_output($sformatf("rst_stage%0d", s), 32'(dut_tag(s)), 32'(BUBBLE));
        end
        check_output("rst_cycles", bus.stall_cycles, 32'd0);
        check_output("rst_timeout", 32'(bus.stall_timeout), 32'd0);
        model_reset();
        apply_stimulus(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd3, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_model("post_rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom),
                           2'($urandom), 2'($urandom), 2'($urandom),
                           ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_tag_pipe.md
Name: hazard_tag_pipe

Overview:
- Write-side companion of the hazard controller in the 5-stage MIPS pipeline.
- Carries each instruction's hazard tag through the E, M and W stage registers: register numbers, write number and enable, T_use and T_new.
- Consumes the stall decision, inserts bubbles, and drives the tag inputs the hazard controller reads.
- Also drives the PC and F/D enables plus stall statistics and watchdog status.

Parameters:
- WDOG_LIMIT, 16, number of consecutive stall cycles after which stall_timeout is raised.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  stall request from the hazard controller
- D_rs_base  in  5  rs/base field of the instruction in D
- D_rt  in  5  rt field of the instruction in D
- D_T_use_rs_base  in  2  T_use of rs/base at D
- D_T_use_rt  in  2  T_use of rt at D
- D_T_new  in  2  T_new as seen on entry to E
- D_REG_write_number  in  5  destination register of the D instruction
- D_REG_write_enable  in  1  D instruction writes the register file
- E_/M_/W_rs_base  out  5 each  stage tag, rs/base
- E_/M_/W_rt  out  5 each  stage tag, rt
- E_/M_/W_T_use_rs_base  out  2 each  stage tag, T_use of rs/base
- E_/M_/W_T_use_rt  out  2 each  stage tag, T_use of rt
- E_/M_/W_T_new  out  2 each  stage tag, T_new
- E_/M_/W_REG_write_number  out  5 each  stage destination register
- E_/M_/W_REG_write_enable  out  1 each  stage write enable
- PC_enable  out  1  PC update enable
- FD_enable  out  1  F/D register load enable
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - reset_n low clears everything asynchronously. Every stage holds the BUBBLE tag.
  - BUBBLE tag: rs_base=0, rt=0, write_number=0, write_enable=0, T_new=T_NEW_IGNORE (2'd3), both T_use=T_USE_NONE (2'd3).
  - stall_cycles=0, stall_timeout=0.
- Combinational outputs:
  - PC_enable = FD_enable = !stall.
  - Only these two outputs are combinational; all others are registered.
- Stage advance, every cycle:
  - W <= age(M); M <= age(E).
  - E <= BUBBLE if stall is high, else E <= D tag taken unaged (D_T_new is already the E-relative value).
- age() function:
  - Applied to T_new and to both T_use fields.
  - Value 3 stays 3; value 0 stays 0; otherwise decrement by 1.
  - All other fields are copied unchanged.
- Write-enable normalisation on E entry:
  - If D_REG_write_enable=0 or D_REG_write_number=0, latch write_enable=0, write_number=0, T_new=3.
  - This guarantees that $0 never creates a hazard.
- Latency: a D instruction appears at E 1 cycle after a non-stalled edge, at M after 2, at W after 3.
- Stall cycle counter:
  - stall_cycles increments on every edge where stall=1.
  - It saturates at all-ones and never wraps.
- Watchdog:
  - Internal run counter clears on any cycle with stall=0 and increments (saturating) while stall=1.
  - When the run counter reaches WDOG_LIMIT, stall_timeout sets and stays set until reset.
- Reset mid-stall: all stages become BUBBLE immediately. The in-flight tag is discarded and no partial state survives.
- Simultaneous events: stall=1 with D_REG_write_enable=1 still inserts a BUBBLE into E, and the D tag is re-presented next cycle because FD is held upstream.

Decomposition:
- Shared package (macros file) holds:
  - T_NEW_IGNORE=2'd3, T_USE_NONE=2'd3.
  - The BUBBLE field values.
  - Tag field widths.
- One natural sub-module, hazard_tag_stage: a single tag register with a load/bubble select and the age() function. Instantiate it three times (E, M, W).
- The counter and watchdog stay in the top module.

Test Plan:
- Reset: reset_n=0 mid-run -> every E/M/W write_enable=0, T_new=3; stall_cycles=0; stall_timeout=0 without waiting for a clock edge.
- Flow: load with D_REG_write_number=8, write_enable=1, T_new=2, no stall -> E shows T_new=2, then M shows 1, then W shows 0, on successive cycles.
- Load-use: stall=1 for one cycle with D tag T_new=2 -> E=BUBBLE; PC_enable=FD_enable=0 in that cycle; the previous E tag advances to M with T_new decremented.
- $0 write: D_REG_write_number=0, write_enable=1, T_new=1 -> E shows write_enable=0, T_new=3.
- Saturation: T_use_rt=1 entering E -> M shows 0 and W shows 0; T_use=3 stays 3 in every stage.
- Watchdog: stall held high for 16 cycles -> stall_timeout rises on the 16th edge and stays high after stall drops; stall_cycles=16.
